// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded multi-port register file.
package regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   localparam int ZERO_ADDR = 0;

   // Address width for a register count; at least one bit even for tiny files.
   function automatic int rf_addr_width(input int regno);
      return (regno > 1) ? $clog2(regno) : 1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, issue sets, writeback clears,
// and a set in the same cycle as a clear on the same register wins.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REGNO    = 32,
   parameter int NRD      = 2,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    busy
);

   // Full power-of-two depth so any address indexes safely; unused bits stay 0.
   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] pending_reg;
   logic [DEPTH-1:0] pending_next;
   logic [DEPTH-1:0] settable;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mask
         assign settable[gi] = (gi < REGNO) && !((ZERO_REG != 0) && (gi == ZERO_ADDR));
      end
   endgenerate

   always_comb begin
      pending_next = pending_reg;
      if (en && wr_en)
         pending_next[wr_addr] = 1'b0;
      if (en && iss_en)
         pending_next[iss_addr] = 1'b1;
      pending_next = pending_next & settable;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending_reg <= '0;
      else
         pending_reg <= pending_next;
   end

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_busy
         assign busy[gi] = pending_reg[rd_addr[gi*AW +: AW]];
      end
   endgenerate

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with clear-on-reset sequencer and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int REGNO    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = rf_addr_width(REGNO)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 ready,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr
);

   rf_state_t         state_reg, state_next;
   logic [AW-1:0]     clr_cnt_reg, clr_cnt_next;
   logic              run;
   logic              wr_ok;
   logic [NRD-1:0]    sb_busy;
   logic [WIDTH-1:0]  mem [REGNO];

   // Addresses that map to real storage: in range and not the hardwired zero.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (int'(a) < REGNO) && !((ZERO_REG != 0) && (a == AW'(ZERO_ADDR)));
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= RF_CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (state_reg == RF_CLEAR) begin
         clr_cnt_next = clr_cnt_reg + AW'(1);
         if (clr_cnt_reg == AW'(REGNO - 1)) begin
            state_next   = RF_RUN;
            clr_cnt_next = '0;
         end
      end
   end

   assign run   = (state_reg == RF_RUN);
   assign ready = run;
   assign wr_ok = run && wr_en && addr_live(wr_addr);

   // Storage has no reset; the clear sequence zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (state_reg == RF_CLEAR)
         mem[clr_cnt_reg] <= '0;
      else if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   regfile_scoreboard #(
      .REGNO    (REGNO),
      .NRD      (NRD),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (run),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .busy     (sb_busy)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]    ra;
         logic [WIDTH-1:0] port_data;
         logic             byp;

         assign ra = rd_addr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
         assign byp = wr_ok && (wr_addr == ra);
`else
         assign byp = 1'b0;
`endif

         always_comb begin
            port_data = '0;
            if (byp)
               port_data = wr_data;
            else if (run && addr_live(ra))
               port_data = mem[ra];
         end

         assign rd_data[gi*WIDTH +: WIDTH] = port_data;
         assign rd_busy[gi] = run && sb_busy[gi] && !byp;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a 32-entry and a 20-entry instance share stimulus.
module tb_regfile_mp_sb;

   localparam int AW = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  rd_addr = '0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        iss_en = 1'b0;
   logic [4:0]  iss_addr = '0;

   logic        ready_a, ready_b;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_busy_a, rd_busy_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_mp_sb #(.WIDTH(32), .REGNO(32), .NRD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ready(ready_a),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr)
   );

   regfile_mp_sb #(.WIDTH(32), .REGNO(20), .NRD(2), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .ready(ready_b),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
   endtask

   task automatic read2(input logic [4:0] a1, input logic [4:0] a0);
      rd_addr = {a1, a0};
      #1;
   endtask

   initial begin
      // Test 1: reset and clear sequence
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready_a", 64'(ready_a), 64'd0);
      chk("rst_ready_b", 64'(ready_b), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         chk($sformatf("clr_ready_a_%0d", k), 64'(ready_a), 64'd0);
         if (k == 19) chk("clr_ready_b_19", 64'(ready_b), 64'd0);
         if (k == 20) chk("clr_ready_b_20", 64'(ready_b), 64'd1);
         if (k == 10) chk("clr_rd_data_zero", rd_data_a, 64'd0);
         step();
      end
      chk("clr_ready_a_32", 64'(ready_a), 64'd1);
      for (int a = 0; a < 32; a += 2) begin
         read2(5'(a + 1), 5'(a));
         chk($sformatf("post_clr_data_%0d", a), rd_data_a, 64'd0);
         chk($sformatf("post_clr_busy_%0d", a), 64'(rd_busy_a), 64'd0);
      end

      // Test 2: write then read, zero register
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      step();
      idle();
      read2(5'd5, 5'd5);
      chk("wr5_both_ports", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      iss_en = 1'b1; iss_addr = 5'd0;
      step();
      idle();
      read2(5'd0, 5'd0);
      chk("reg0_data", rd_data_a, 64'd0);
      chk("reg0_busy", 64'(rd_busy_a), 64'd0);

      // Test 3: scoreboard set / set-wins / clear
      iss_en = 1'b1; iss_addr = 5'd7;
      step();
      idle();
      read2(5'd7, 5'd7);
      chk("iss7_busy", 64'(rd_busy_a), 64'd3);
      iss_en = 1'b1; iss_addr = 5'd7;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
      step();
      idle();
      #1;
      chk("iss_wr7_still_busy", 64'(rd_busy_a), 64'd3);
      chk("iss_wr7_data", rd_data_a, {32'h77, 32'h77});
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h88;
      step();
      idle();
      #1;
      chk("wr7_busy_clear", 64'(rd_busy_a), 64'd0);

      // Test 4: same-cycle read of a register being written
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11111111;
      iss_en = 1'b1; iss_addr = 5'd9;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      read2(5'd9, 5'd5);
`ifdef REGFILE_BYPASS_EN
      chk("byp_same_cycle_data", rd_data_a, {32'hA5A5A5A5, 32'hDEADBEEF});
      chk("byp_same_cycle_busy", 64'(rd_busy_a), 64'd0);
`else
      chk("nobyp_same_cycle_data", rd_data_a, {32'h11111111, 32'hDEADBEEF});
      chk("nobyp_same_cycle_busy", 64'(rd_busy_a), 64'd2);
`endif
      step();
      idle();
      #1;
      chk("wr9_next_data", rd_data_a, {32'hA5A5A5A5, 32'hDEADBEEF});
      chk("wr9_next_busy", 64'(rd_busy_a), 64'd0);

      // Test 6: 20-entry instance boundaries (addresses >= REGNO)
      wr_en = 1'b1; wr_addr = 5'd19; wr_data = 32'h13;
      step();
      wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'hFFFFFFFF;
      iss_en = 1'b1; iss_addr = 5'd25;
      step();
      idle();
      read2(5'd25, 5'd19);
      chk("b_rd19_rd25", rd_data_b, {32'd0, 32'h13});
      chk("b_busy25", 64'(rd_busy_b), 64'd0);
      chk("a_rd25_written", rd_data_a[63:32], 64'hFFFFFFFF);
      chk("a_busy25", 64'(rd_busy_a), 64'd2);

      // Test 5: reset in the middle of a pending write
      iss_en = 1'b1; iss_addr = 5'd3;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE;
      read2(5'd3, 5'd3);
      chk("pre_rst_busy3", 64'(rd_busy_a), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(ready_a), 64'd0);
      chk("midrst_busy", 64'(rd_busy_a), 64'd0);
      step();
      rst_n = 1'b1;
      idle();
      for (int k = 0; k < 32; k++) begin
         if (k == 31) chk("midrst_ready_31", 64'(ready_a), 64'd0);
         step();
      end
      chk("midrst_ready_32", 64'(ready_a), 64'd1);
      read2(5'd5, 5'd3);
      chk("midrst_reg3_reg5", rd_data_a, 64'd0);
      chk("midrst_busy_after", 64'(rd_busy_a), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
